// File: rtl/maj_bist_checker_pkg.sv
// Shared types and helpers for the majority BIST checker.
package maj_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Widest supported majority block; popcount works on a vector of this width.
  localparam int unsigned MAX_N = 15;

  // Number of ones in v; 4 bits hold up to 15.
  function automatic logic [3:0] popcount(input logic [MAX_N-1:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < MAX_N; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  // Minimum number of ones for a majority of n inputs.
  function automatic logic [3:0] maj_thresh(input int unsigned n);
    return 4'((n + 1) / 2);
  endfunction

endpackage

// File: rtl/maj_bist_checker_if.sv
// Signal bundle between the BIST checker and the block under test / controller.
interface maj_bist_checker_if #(
  parameter int unsigned N = 13
);
  logic         start;
  logic [N-1:0] dut_x;
  logic         dut_y;
  logic         busy;
  logic         done;
  logic         pass;
  logic [N:0]   err_cnt;
  logic         first_fail_valid;
  logic [N-1:0] first_fail_vec;

  // Checker side: drives vectors and status, reads start and the DUT output.
  modport master (
    input  start,
    input  dut_y,
    output dut_x,
    output busy,
    output done,
    output pass,
    output err_cnt,
    output first_fail_valid,
    output first_fail_vec
  );

  // Environment side: the majority block plus whoever issues start.
  modport slave (
    output start,
    output dut_y,
    input  dut_x,
    input  busy,
    input  done,
    input  pass,
    input  err_cnt,
    input  first_fail_valid,
    input  first_fail_vec
  );
endinterface

// File: rtl/maj_bist_checker_ref.sv
// Golden majority reference; a separate module so a netlist can replace it.
module maj_ref
  import maj_bist_pkg::*;
#(
  parameter int unsigned N = 13
) (
  input  logic [N-1:0] v_i,
  output logic         y_o
);

  logic [MAX_N-1:0] v_ext;

  assign v_ext = MAX_N'(v_i);
  assign y_o   = (popcount(v_ext) >= maj_thresh(N));

endmodule

// File: rtl/maj_bist_checker.sv
// Exhaustive on-chip tester for an N-input majority block.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// RUN     | sweeping dut_x from 0 to all ones, comparing every LAT cycles
// DONE    | sweep finished, results held until the next start
module maj_bist_checker
  import maj_bist_pkg::*;
#(
  parameter int unsigned N   = 13,
  parameter int unsigned LAT = 1
) (
  input logic              clk,
  input logic              rst,
  maj_bist_checker_if.master bus
);

  if ((N % 2) == 0 || N < 3 || N > MAX_N) begin : g_bad_n
    $error("maj_bist_checker: N must be odd and within 3..15");
  end
  if (LAT < 1 || LAT > 15) begin : g_bad_lat
    $error("maj_bist_checker: LAT must be within 1..15");
  end

  localparam logic [3:0]   WAIT_LOAD = 4'(LAT - 1);
  localparam logic [N-1:0] X_LAST    = {N{1'b1}};
  localparam logic [N-1:0] X_ONE     = N'(1);
  localparam logic [N:0]   ERR_ONE   = (N + 1)'(1);
  localparam logic [N:0]   ERR_MAX   = {1'b1, {N{1'b0}}};

  state_e       state_q, state_d;
  logic [N-1:0] x_q, x_d;
  logic [3:0]   wcnt_q, wcnt_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         pass_q, pass_d;
  logic [N:0]   err_q, err_d;
  logic         ffv_q, ffv_d;
  logic [N-1:0] ffvec_q, ffvec_d;

  logic         ref_y;
  logic         match;
  logic [N:0]   err_nxt;

  maj_ref #(.N(N)) u_ref (
    .v_i (x_q),
    .y_o (ref_y)
  );

  // State and result registers; reset aborts any run in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      wcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      wcnt_q  <= wcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
    end
  end

  // Next-state: start handling, latency wait, compare and vector stepping.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    wcnt_d  = wcnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;

    // An unknown dut_y falls through to a mismatch.
    match = 1'b0;
    if (bus.dut_y == ref_y) begin
      match = 1'b1;
    end
    err_nxt = (!match && err_q != ERR_MAX) ? err_q + ERR_ONE : err_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          x_d     = '0;
          wcnt_d  = WAIT_LOAD;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          ffv_d   = 1'b0;
          ffvec_d = '0;
        end
      end
      ST_RUN: begin
        if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else begin
          err_d = err_nxt;
          if (!match && !ffv_q) begin
            ffv_d   = 1'b1;
            ffvec_d = x_q;
          end
          if (x_q != X_LAST) begin
            x_d    = x_q + X_ONE;
            wcnt_d = WAIT_LOAD;
          end else begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_nxt == '0);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.dut_x            = x_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.err_cnt          = err_q;
  assign bus.first_fail_valid = ffv_q;
  assign bus.first_fail_vec   = ffvec_q;

endmodule

// File: doc/maj_bist_checker.md
Name: maj_bist_checker

Overview:
Synthesizable on-chip exhaustive tester for an N-input majority block. It is the sequential counterpart of the exhaustive majority testbench: it drives every N-bit vector into the DUT and samples the DUT's single output. Each sample is compared against an internal popcount-threshold reference, and the block reports pass/fail, the mismatch count and the first failing vector. It sits beside a mapped majority netlist in the hardware flow, so the netlist can be signed off in silicon or FPGA without a simulator.

Parameters:
N, 13, DUT input width; must be odd, range 3..15; elaboration error otherwise.
LAT, 1, cycles from driving dut_x to sampling dut_y; range 1..15; covers combinational DUTs (1) and registered DUTs (>1).

Ports:
clk  in  1  single clock, rising-edge.
rst  in  1  asynchronous active-high reset.
start  in  1  one-cycle pulse; begins a run when idle.
dut_x  out  N  vector driven to DUT inputs x0..x(N-1); bit i drives xi.
dut_y  in  1  DUT output y0.
busy  out  1  high while a run is in progress.
done  out  1  high once a run completes; sticky until next accepted start or reset.
pass  out  1  valid when done=1; 1 iff err_cnt==0.
err_cnt  out  N+1  number of mismatching vectors in the current/last run.
first_fail_valid  out  1  set on first mismatch of a run.
first_fail_vec  out  N  vector value at first mismatch; holds until next accepted start.

Behaviour:
- Reset (async assert, sync deassert by the integrating design) sets all of the following to zero: FSM=IDLE, dut_x, busy, done, pass, err_cnt, first_fail_valid, first_fail_vec, wait counter.
- Reference function: ref(v) = (popcount(v) >= (N+1)/2). For N=13 this is at least 7 ones.
- FSM states are IDLE, RUN, DONE.
- IDLE/DONE:
  - start=1 at edge E0 moves the FSM to RUN.
  - The same edge sets busy=1, done=0, pass=0, dut_x=0, clears err_cnt, first_fail_valid and first_fail_vec, and loads the wait counter with LAT-1.
- RUN:
  - The wait counter decrements each cycle.
  - When it reads 0, the next edge samples dut_y and compares it with ref(dut_x).
  - That same edge:
    - on mismatch, increments err_cnt;
    - on the first mismatch of the run, sets first_fail_valid=1 and captures first_fail_vec=dut_x;
    - if dut_x != 2^N-1, increments dut_x and reloads the wait counter with LAT-1;
    - otherwise moves to DONE, with busy=0, done=1 and pass=(final err_cnt==0).
- Timing: vector v is compared at edge E0+(v+1)*LAT. done rises at edge E0+2^N*LAT, so a full run takes 2^N*LAT cycles after the start edge.
- dut_x holds its last value (all ones) in DONE and returns to 0 only on the next accepted start.
- start while busy=1 is ignored, with no effect on any state.
- start coincident with the final compare edge is ignored, because busy is still 1 in that cycle.
- err_cnt width N+1 holds the maximum of 2^N. No overflow is possible, but the increment saturates at 2^N as a guard.
- dut_x wrap-around never occurs: the increment is suppressed at 2^N-1.
- X on dut_y counts as a mismatch, since the compare is "equal to ref" evaluated with 1'b1/1'b0 only.
- Reset mid-run aborts immediately. All outputs go to their reset values, and no partial result is retained.

Decomposition:
- Package maj_bist_pkg:
  - state enum (IDLE, RUN, DONE);
  - function popcount(N-bit) returning $clog2(N+1) bits;
  - function maj_thresh(N)=(N+1)/2.
- Sub-module maj_ref (combinational, parameter N): computes ref(v). Kept separate so it can be swapped for a golden netlist.

Test Plan:
- N=13, LAT=1, behavioural correct majority DUT; start pulse at E0 -> done=1 exactly 8192 cycles later, pass=1, err_cnt=0, first_fail_valid=0, dut_x=13'h1FFF.
- DUT stuck-at-0 -> err_cnt=4096, pass=0, first_fail_valid=1, first_fail_vec=13'h007F.
- DUT inverted majority -> err_cnt=8192, first_fail_vec=13'h0000.
- DUT majority with a single injected fault at x=13'h0AAA -> err_cnt=1, first_fail_vec=13'h0AAA. Repeat with LAT=3 and a 3-stage-registered DUT: done 24576 cycles after start, result identical.
- Reset asserted asynchronously while dut_x=100 -> all outputs 0 within the same cycle; a new start gives the full correct run result.
- Extra start pulses at dut_x=5 and at the final compare edge -> ignored: a single run, done once, counts unchanged. A start in DONE clears done, err_cnt and first_fail_* on that edge.
